// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: steps one dot-product command (bias, N operand pairs) through an external
// registered MAC PE and presents the accumulated result. PE_SEQ_PERF_EN adds perf_stall_cnt.
module pe_seq_ctrl #(
    parameter int ACT_WIDTH    = 16,
    parameter int WGT_WIDTH    = 16,
    parameter int PE_OUT_WIDTH = 48,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_mode_8bit,
    input  logic [PE_OUT_WIDTH-1:0] cmd_bias,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [ACT_WIDTH-1:0]    op_a,
    input  logic [WGT_WIDTH-1:0]    op_b,
    output logic [ACT_WIDTH-1:0]    pe_a,
    output logic [WGT_WIDTH-1:0]    pe_b,
    output logic [PE_OUT_WIDTH-1:0] pe_c,
    output logic                    pe_choose_8bit,
    input  logic [PE_OUT_WIDTH-1:0] pe_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [PE_OUT_WIDTH-1:0] res_data,
    output logic                    res_mode_8bit,
    output logic                    busy,
`ifdef PE_SEQ_PERF_EN
    output logic [31:0]             perf_stall_cnt,
`endif
    output logic [2:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // valid never waits on ready, and ready depends only on the current state.
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic                    r_mode;
    logic [PE_OUT_WIDTH-1:0] r_bias;
    logic                    w_cmd_fire;
    logic                    w_op_fire;

    assign w_cmd_fire    = (r_state == S_IDLE) && cmd_valid;
    assign w_op_fire     = (r_state == S_RUN) && op_valid;
    assign res_data      = pe_out;
    assign res_mode_8bit = r_mode;
    assign dbg_state     = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_remaining <= '0;
            r_mode      <= 1'b0;
            r_bias      <= '0;
        end else if (w_cmd_fire) begin
            r_len       <= cmd_len;
            r_remaining <= cmd_len;
            r_mode      <= cmd_mode_8bit;
            r_bias      <= cmd_bias;
        end else if (w_op_fire && (r_remaining != '0)) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
    end

    // Outside IDLE and PRIME the PE feeds its own result back, so bubbles hold the sum.
    always_comb begin
        w_next         = r_state;
        cmd_ready      = 1'b0;
        op_ready       = 1'b0;
        res_valid      = 1'b0;
        busy           = 1'b1;
        pe_a           = '0;
        pe_b           = '0;
        pe_c           = pe_out;
        pe_choose_8bit = r_mode;
        case (r_state)
            S_IDLE: begin
                cmd_ready      = 1'b1;
                busy           = 1'b0;
                pe_c           = '0;
                pe_choose_8bit = 1'b0;
                if (cmd_valid) begin
                    w_next = S_PRIME;
                end
            end
            S_PRIME: begin
                pe_c   = r_bias;
                w_next = (r_len != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    pe_a = op_a;
                    pe_b = op_b;
                    if (r_remaining <= LEN_WIDTH'(1)) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef PE_SEQ_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_cmd_fire) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !op_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: bench with a stand-in registered MAC PE and a transaction-timeline model
// of the sequencer that is compared against the DUT on every cycle.
module tb_pe_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = '0;
    logic        cmd_mode_8bit = 1'b0;
    logic [47:0] cmd_bias = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] pe_a;
    logic [15:0] pe_b;
    logic [47:0] pe_c;
    logic        pe_choose_8bit;
    logic [47:0] pe_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic        res_mode_8bit;
    logic        busy;
    logic [2:0]  dbg_state;
`ifdef PE_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    pe_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_mode_8bit(cmd_mode_8bit), .cmd_bias(cmd_bias),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_choose_8bit(pe_choose_8bit), .pe_out(pe_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_mode_8bit(res_mode_8bit), .busy(busy),
`ifdef PE_SEQ_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in PE: 16-bit MAC, or two 23-bit lanes (a bytes times the low byte of b).
    function automatic logic [47:0] pe_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [47:0] c, input logic m);
        logic signed [47:0] sa, sb;
        logic signed [23:0] al, ah, bl;
        logic [23:0] lo, hi;
        if (!m) begin
            sa = {{32{a[15]}}, a};
            sb = {{32{b[15]}}, b};
            return sa * sb + c;
        end
        al = {{16{a[7]}}, a[7:0]};
        ah = {{16{a[15]}}, a[15:8]};
        bl = {{16{b[7]}}, b[7:0]};
        lo = al * bl + c[23:0];
        hi = ah * bl + c[47:24];
        return {1'b0, hi[22:0], 1'b0, lo[22:0]};
    endfunction

    always @(posedge clk) begin
        if (reset) pe_out <= '0;
        else       pe_out <= pe_fn(pe_a, pe_b, pe_c, pe_choose_8bit);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [47:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: one command timeline (accept cycle, operands taken, cycle of last operand).
    logic        m_known = 1'b0;
    logic        m_active = 1'b0;
    int          m_t = 0;
    int          m_len = 0;
    int          m_ops = 0;
    int          m_finish = -1;
    logic        m_mode = 1'b0;
    logic [47:0] m_bias = '0;
    logic [47:0] m_acc = '0;
    logic [31:0] m_stall = '0;
    logic        m_seen_res = 1'b0;
    int          res_cycle = 0;
    logic [47:0] res_first = '0;
    logic        res_mode_first = 1'b0;
    logic [47:0] m_last_exp = '0;
    int          op_ready_hi = 0;

    always @(negedge clk) begin
        logic        e_op_ready, e_res_valid;
        logic [15:0] e_a, e_b;
        logic [47:0] e_c;
        e_op_ready  = m_active && (cyc >= m_t + 2) && (m_ops < m_len);
        e_res_valid = m_active && (m_finish >= 0) && (cyc >= m_finish + 2);
        e_a = (e_op_ready && op_valid) ? op_a : 16'h0;
        e_b = (e_op_ready && op_valid) ? op_b : 16'h0;
        e_c = !m_active ? 48'h0 : ((cyc == m_t + 1) ? m_bias : pe_out);
        if (m_known) begin
            check("cmd_ready", 64'(cmd_ready), 64'(!m_active));
            check("busy", 64'(busy), 64'(m_active));
            check("op_ready", 64'(op_ready), 64'(e_op_ready));
            check("res_valid", 64'(res_valid), 64'(e_res_valid));
            check("pe_choose_8bit", 64'(pe_choose_8bit), 64'(m_active & m_mode));
            check("pe_a", 64'(pe_a), 64'(e_a));
            check("pe_b", 64'(pe_b), 64'(e_b));
            check("pe_c", 64'(pe_c), 64'(e_c));
`ifdef PE_SEQ_PERF_EN
            check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif
            if (op_ready) op_ready_hi++;
            if (e_res_valid) begin
                if (!m_seen_res) begin
                    m_seen_res = 1'b1;
                    res_cycle = cyc;
                    res_first = res_data;
                    res_mode_first = res_mode_8bit;
                end
                if (exp_q.size() > 0) check("res_data", 64'(res_data), 64'(exp_q[0]));
                check("res_mode_8bit", 64'(res_mode_8bit), 64'(m_mode));
            end
        end
        // advance the model to the next cycle
        if (reset) begin
            m_known = 1'b1;
            m_active = 1'b0;
            m_stall = '0;
            exp_q.delete();
        end else if (m_known) begin
            if (!m_active) begin
                if (cmd_valid) begin
                    m_active = 1'b1;
                    m_t = cyc;
                    m_len = int'(cmd_len);
                    m_mode = cmd_mode_8bit;
                    m_bias = cmd_bias;
                    m_ops = 0;
                    m_stall = '0;
                    m_seen_res = 1'b0;
                    op_ready_hi = 0;
                    m_acc = pe_fn(16'h0, 16'h0, cmd_bias, cmd_mode_8bit);
                    m_finish = -1;
                    if (m_len == 0) begin
                        m_finish = cyc + 1;
                        m_last_exp = m_acc;
                        exp_q.push_back(m_acc);
                    end
                end
            end else begin
                if (e_op_ready) begin
                    if (op_valid) begin
                        m_acc = pe_fn(op_a, op_b, m_acc, m_mode);
                        m_ops++;
                        if (m_ops == m_len) begin
                            m_finish = cyc;
                            m_last_exp = m_acc;
                            exp_q.push_back(m_acc);
                        end
                    end else if (m_stall != 32'hFFFF_FFFF) begin
                        m_stall = m_stall + 32'd1;
                    end
                end
                if (e_res_valid && res_ready) begin
                    m_active = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [15:0] op_a_tab[8];
    logic [15:0] op_b_tab[8];
    int          gap_tab[8];

    task automatic send_cmd(input int len, input logic mode, input logic [47:0] bias);
        int w;
        cmd_valid = 1'b1;
        cmd_len = 16'(len);
        cmd_mode_8bit = mode;
        cmd_bias = bias;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_accept_timeout cycle %0d: got cmd_ready=0 expected 1", cyc);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int gap);
        int w;
        op_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!op_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL op_accept_timeout cycle %0d: got op_ready=0 expected 1", cyc);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
    endtask

    task automatic take_result(input int delay);
        int w;
        res_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!res_valid && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!res_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL result_timeout cycle %0d: got res_valid=0 expected 1", cyc);
        end
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_cmd(input int len, input logic mode, input logic [47:0] bias,
                           input int res_delay, input logic noise);
        send_cmd(len, mode, bias);
        if (noise) begin
            cmd_valid = 1'b1;
            cmd_len = 16'd7;
        end
        for (int i = 0; i < len; i++) send_op(op_a_tab[i], op_b_tab[i], gap_tab[i]);
        cmd_valid = 1'b0;
        take_result(res_delay);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pe_c", 64'(pe_c), 64'd0);
        @(posedge clk);
        #1;

        // 16-bit, bias 5, three operands back to back
        op_a_tab[0] = 16'd2;      op_b_tab[0] = 16'd3;      gap_tab[0] = 0;
        op_a_tab[1] = 16'd4;      op_b_tab[1] = 16'hFFFF;   gap_tab[1] = 0;
        op_a_tab[2] = 16'hFFF9;   op_b_tab[2] = 16'd2;      gap_tab[2] = 0;
        run_cmd(3, 1'b0, 48'd5, 0, 1'b0);
        check("dp3_model", 64'(m_last_exp), 64'h0000_FFFF_FFFF_FFF9);
        check("dp3_data", 64'(res_first), 64'h0000_FFFF_FFFF_FFF9);
        check("dp3_latency", 64'(res_cycle - m_t), 64'd6);
        check("dp3_mode", 64'(res_mode_first), 64'd0);

        // dual 8-bit lanes
        op_a_tab[0] = 16'h0302;   op_b_tab[0] = 16'hFFFE;   gap_tab[0] = 0;
        run_cmd(1, 1'b1, 48'd0, 1, 1'b0);
        check("lane8_model", 64'(m_last_exp), 64'h0000_7FFF_FA7F_FFFC);
        check("lane8_data", 64'(res_first), 64'h0000_7FFF_FA7F_FFFC);
        check("lane8_mode", 64'(res_mode_first), 64'd1);

        // bubbles between operands and a stalled result
        op_a_tab[0] = 16'd1;      op_b_tab[0] = 16'd1;      gap_tab[0] = 0;
        op_a_tab[1] = 16'd2;      op_b_tab[1] = 16'd2;      gap_tab[1] = 3;
        run_cmd(2, 1'b0, 48'd0, 4, 1'b0);
        check("bubble_data", 64'(res_first), 64'd5);
`ifdef PE_SEQ_PERF_EN
        check("bubble_stalls", 64'(perf_stall_cnt), 64'd3);
`endif

        // zero-length command
        run_cmd(0, 1'b0, 48'd100, 0, 1'b0);
        check("len0_data", 64'(res_first), 64'd100);
        check("len0_latency", 64'(res_cycle - m_t), 64'd3);
        check("len0_op_ready_cycles", 64'(op_ready_hi), 64'd0);

        // reset in the second RUN cycle aborts the command
        send_cmd(4, 1'b0, 48'd9);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        op_a_tab[0] = 16'd3;      op_b_tab[0] = 16'd4;      gap_tab[0] = 0;
        run_cmd(1, 1'b0, 48'd1, 0, 1'b0);
        check("after_abort_data", 64'(res_first), 64'd13);

        // cmd_valid held high with another length while running
        op_a_tab[0] = 16'd2;      op_b_tab[0] = 16'd3;      gap_tab[0] = 0;
        op_a_tab[1] = 16'd1;      op_b_tab[1] = 16'd1;      gap_tab[1] = 1;
        run_cmd(2, 1'b0, 48'd0, 0, 1'b1);
        check("busy_cmd_data", 64'(res_first), 64'd7);

        // randomized commands
        for (int n = 0; n < 24; n++) begin
            int len;
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                op_a_tab[i] = 16'($urandom);
                op_b_tab[i] = 16'($urandom);
                gap_tab[i] = $urandom_range(0, 2);
            end
            run_cmd(len, 1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)},
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameters: ACT_WIDTH 16, activation width; WGT_WIDTH 16, weight width; PE_OUT_WIDTH 48, accumulator width; LEN_WIDTH 16, dot-product length width.
REQ-002 SHALL have ports: clk in 1, clock; reset in 1, reset (synchronous, active-high); clock clk.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_len in LEN_WIDTH, operand count; cmd_mode_8bit in 1, 1=dual 8-bit lanes; cmd_bias in PE_OUT_WIDTH, initial accumulator.
REQ-004 SHALL have operand ports: op_valid in 1; op_ready out 1; op_a in ACT_WIDTH; op_b in WGT_WIDTH.
REQ-005 SHALL have PE-side ports: pe_a out ACT_WIDTH; pe_b out WGT_WIDTH; pe_c out PE_OUT_WIDTH; pe_choose_8bit out 1; pe_out in PE_OUT_WIDTH, registered PE result with 1-cycle latency.
REQ-006 SHALL have result ports: res_valid out 1; res_ready in 1; res_data out PE_OUT_WIDTH; res_mode_8bit out 1; busy out 1.

Function
REQ-007 SHALL implement FSM states IDLE, PRIME, RUN, DRAIN, DONE.
REQ-008 IDLE: cmd_ready=1. On cmd_valid, SHALL latch len, mode and bias, then go to PRIME.
REQ-009 PRIME, one cycle: pe_a=0, pe_b=0, pe_c=bias, so pe_out=bias next cycle. Next state is RUN if len>0, else DRAIN.
REQ-010 RUN: op_ready=1.
- On op_valid&op_ready: pe_a=op_a, pe_b=op_b, pe_c=pe_out; decrement remaining count.
- On bubble (op_valid=0): pe_a=0, pe_b=0, pe_c=pe_out, so the accumulator holds.
REQ-011 RUN SHALL go to DRAIN on the cycle the last operand is accepted. The remaining count SHALL never wrap below zero.
REQ-012 DRAIN, one cycle: hold inputs (a=b=0, c=pe_out), then go to DONE.
REQ-013 DONE: res_valid=1, res_data=pe_out, res_mode_8bit=latched mode; PE inputs held (a=b=0, c=pe_out) so res_data stays stable. On res_ready, go to IDLE.
REQ-014 pe_choose_8bit SHALL equal the latched mode in PRIME through DONE, and 0 in IDLE.
REQ-015 Latency, no bubbles: command accepted in cycle T, len=N gives res_valid first high at T+3+N.
REQ-016 cmd_ready=0 outside IDLE. cmd_valid SHALL be ignored while busy. op_ready=0 outside RUN.
REQ-017 busy=1 in every state except IDLE.
REQ-018 In IDLE, PE inputs SHALL be a=0, b=0, c=0.
REQ-019 Block SHALL do no arithmetic. 8-bit lane masking and packing are performed by the PE; res_data is pe_out unmodified.

Reset
REQ-020 Reset SHALL force state IDLE in the next cycle, from any state including mid-RUN.
REQ-021 Reset values: cmd_ready=1 after reset, op_ready=0, res_valid=0, busy=0, pe_a/pe_b/pe_c=0, pe_choose_8bit=0, latched len/mode/bias=0.
REQ-022 An in-flight command aborted by reset SHALL produce no result.

Configuration
REQ-023 Macro PE_SEQ_PERF_EN defined: SHALL add output perf_stall_cnt, 32 bits.
- Counts RUN cycles with op_valid=0.
- Clears on command accept; saturates at 0xFFFFFFFF; reset value 0.
REQ-024 Macro PE_SEQ_PERF_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-025 16-bit mode, bias=5, len=3, ops (2,3),(4,-1),(-7,2), no bubbles -> res_data=-7 (0xFFFFFFFFFFF9) at T+6, res_mode_8bit=0.
REQ-026 8-bit mode, bias=0, len=1, op_a=0x0302, op_b=0xFFFE -> res_data=0x7FFFFA7FFFFC, res_mode_8bit=1.
REQ-027 16-bit mode, len=2, ops (1,1),(2,2), op_valid low 3 cycles between ops, res_ready low 4 cycles in DONE -> res_data=5 stable while res_valid held; perf_stall_cnt=3 when PE_SEQ_PERF_EN.
REQ-028 len=0, bias=100 -> res_data=100 at T+3; op_ready never asserted.
REQ-029 Reset asserted in second RUN cycle -> next cycle IDLE, cmd_ready=1, busy=0, res_valid stays 0; next command completes normally.
REQ-030 cmd_valid held high during RUN with different len -> ignored, cmd_ready=0; original command's result unchanged.
